// File: rtl/sram_line_en_pkg.sv
// Shared types and helpers for the SRAM line-enable request controller.
package sram_line_en_pkg;

  localparam int unsigned DEF_ADDR_BITS = 10;
  localparam int unsigned DEF_DATA_BITS = 32;

  typedef struct packed {
    logic                     we;
    logic [DEF_ADDR_BITS-1:0] addr;
    logic [DEF_DATA_BITS-1:0] wdata;
  } req_t;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned occ_bits(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_line_en_req_ctrl_if.sv
// Request/response handshake plus SRAM command bus of the line-enable controller.
interface sram_line_en_req_ctrl_if #(
  parameter int unsigned MEM_ADDR_BITS = 10,
  parameter int unsigned MEM_DATA_BITS = 32
);

  logic                     i_req_valid;
  logic                     o_req_ready;
  logic                     i_req_we;
  logic [MEM_ADDR_BITS-1:0] i_req_addr;
  logic [MEM_DATA_BITS-1:0] i_req_wdata;
  logic                     o_rsp_valid;
  logic                     i_rsp_ready;
  logic [MEM_DATA_BITS-1:0] o_rsp_rdata;
  logic                     o_sram_write_en;
  logic                     o_sram_read_en;
  logic [MEM_ADDR_BITS-1:0] o_sram_addr;
  logic [MEM_DATA_BITS-1:0] o_sram_write_data;
  logic [MEM_DATA_BITS-1:0] i_sram_read_data;

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_rsp_ready, i_sram_read_data,
    output o_req_ready, o_rsp_valid, o_rsp_rdata,
           o_sram_write_en, o_sram_read_en, o_sram_addr, o_sram_write_data
  );

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_rsp_ready, i_sram_read_data,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata,
           o_sram_write_en, o_sram_read_en, o_sram_addr, o_sram_write_data
  );

endinterface

// File: rtl/sram_line_en_rsp_fifo.sv
// First-word-fall-through response buffer; pointers wrap modulo DEPTH (any depth >= 2).
module sram_line_en_rsp_fifo
  import sram_line_en_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       valid,
  output logic [WIDTH-1:0]           head,
  output logic [occ_bits(DEPTH)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid  = (count != '0);
  assign head   = mem[rd_ptr];
  assign pop_ok = pop & valid;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= bump(wr_ptr);
      if (pop_ok) rd_ptr <= bump(rd_ptr);
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_line_en_req_ctrl.sv
// Line-enable SRAM request controller: combinational command issue, credit-based
// flow control against a FWFT read-response buffer.
module sram_line_en_req_ctrl
  import sram_line_en_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BITS = 10,
  parameter int unsigned MEM_DATA_BITS = 32,
  parameter int unsigned RSP_DEPTH     = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  sram_line_en_req_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = occ_bits(RSP_DEPTH);

  logic                     run;
  logic                     inflight;
  logic                     req_acc;
  logic                     rd_acc;
  logic                     pop;
  logic                     fifo_valid;
  logic [MEM_DATA_BITS-1:0] fifo_head;
  logic [CNT_W-1:0]         occ;
  logic [CNT_W:0]           credit;
  logic [MEM_ADDR_BITS-1:0] cmd_addr;
  logic [MEM_DATA_BITS-1:0] cmd_wdata;

  assign req_acc = bus.i_req_valid & bus.o_req_ready;
  assign rd_acc  = req_acc & ~bus.i_req_we;
  assign pop     = fifo_valid & bus.i_rsp_ready;
  assign credit  = {1'b0, occ} + {{CNT_W{1'b0}}, inflight};

  // A same-cycle pop frees the slot the new read will eventually need.
  assign bus.o_req_ready = run & ((credit < (CNT_W+1)'(RSP_DEPTH)) | pop);

  assign cmd_addr              = bus.i_req_addr;
  assign cmd_wdata             = bus.i_req_wdata;
  assign bus.o_sram_addr       = cmd_addr;
  assign bus.o_sram_write_data = cmd_wdata;
  assign bus.o_sram_write_en   = req_acc & bus.i_req_we;
  assign bus.o_sram_read_en    = rd_acc;
  assign bus.o_rsp_valid       = fifo_valid;
  assign bus.o_rsp_rdata       = fifo_head;

  // run holds off acceptance until the first clock edge after reset release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run      <= 1'b0;
      inflight <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= rd_acc;
    end
  end

  sram_line_en_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (MEM_DATA_BITS)
  ) u_rsp_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (inflight),
    .push_data (bus.i_sram_read_data),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .count     (occ)
  );

endmodule
